// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - pipeline stall/flush/halt controller with wait watchdog
// Optional stall cycle counter is built only when PIPE_STALL_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             branch_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             halt_req,
    output logic             PCwriteEn,
    output logic             IFIDwriteEn,
    output logic             IDEXwriteEn,
    output logic             EXMEMwriteEn,
    output logic             MEMWBwriteEn,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_BOOT       = 3'd0,
        S_RUN        = 3'd1,
        S_MEM_WAIT   = 3'd2,
        S_FETCH_WAIT = 3'd3,
        S_HALTED     = 3'd4
    } state_t;

    // Control vector: {PC, IFID, IDEX, EXMEM, MEMWB, ifid_flush, idex_flush}
    localparam logic [6:0] C_ALL0  = 7'b00000_00;
    localparam logic [6:0] C_NORM  = 7'b11111_00;
    localparam logic [6:0] C_FETCH = 7'b01111_10;
    localparam logic [6:0] C_BRAN  = 7'b11111_11;
    localparam logic [6:0] C_HAZ   = 7'b00111_01;
    localparam logic [7:0] TO8     = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [6:0] w_ctl;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_nxt;
    logic       r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_BOOT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_BOOT:       w_next = S_RUN;
            S_RUN: begin
                if (halt_req)        w_next = S_HALTED;
                else if (dmem_stall) w_next = S_MEM_WAIT;
                else if (imem_stall) w_next = S_FETCH_WAIT;
            end
            S_MEM_WAIT:   if (!dmem_stall) w_next = S_RUN;
            S_FETCH_WAIT: begin
                if (dmem_stall)       w_next = S_MEM_WAIT;
                else if (!imem_stall) w_next = S_RUN;
            end
            S_HALTED:     w_next = S_HALTED;
            default:      w_next = S_BOOT;
        endcase
    end

    always_comb begin
        w_ctl = C_ALL0;
        case (r_state)
            S_RUN: begin
                if (halt_req || dmem_stall) w_ctl = C_ALL0;
                else if (imem_stall)        w_ctl = C_FETCH;
                else if (branch_taken)      w_ctl = C_BRAN;
                else if (hazard_stall)      w_ctl = C_HAZ;
                else                        w_ctl = C_NORM;
            end
            S_MEM_WAIT:   if (!dmem_stall) w_ctl = C_NORM;
            S_FETCH_WAIT: begin
                if (dmem_stall)      w_ctl = C_ALL0;
                else if (imem_stall) w_ctl = C_FETCH;
                else                 w_ctl = C_NORM;
            end
            default:      w_ctl = C_ALL0;
        endcase
    end

    assign {PCwriteEn, IFIDwriteEn, IDEXwriteEn, EXMEMwriteEn, MEMWBwriteEn,
            ifid_flush, idex_flush} = w_ctl;
    assign halted = (r_state == S_HALTED);
    assign err    = r_err;

    // Counter only advances while staying in the same wait state; any entry restarts it.
    always_comb begin
        w_wait_nxt = 8'd0;
        if ((w_next == S_MEM_WAIT || w_next == S_FETCH_WAIT) && w_next == r_state)
            w_wait_nxt = (r_wait_cnt == TO8) ? r_wait_cnt : r_wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == TO8) r_err <= 1'b1;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (!PCwriteEn && r_state != S_BOOT && r_state != S_HALTED && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed and random checks of pipe_stall_ctrl against a behavioural model
module tb_pipe_stall_ctrl;

    localparam int TO = 15;
    localparam int CW = 16;
`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam longint SMAX = (longint'(1) << CW) - 1;

    localparam logic [6:0] ALL0  = 7'b00000_00;
    localparam logic [6:0] NORM  = 7'b11111_00;
    localparam logic [6:0] FETCH = 7'b01111_10;
    localparam logic [6:0] BRAN  = 7'b11111_11;
    localparam logic [6:0] HAZ   = 7'b00111_01;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hazard_stall = 1'b0, branch_taken = 1'b0, imem_stall = 1'b0;
    logic dmem_stall = 1'b0, halt_req = 1'b0;
    logic PCwriteEn, IFIDwriteEn, IDEXwriteEn, EXMEMwriteEn, MEMWBwriteEn;
    logic ifid_flush, idex_flush, halted, err;
    logic [CW-1:0] stall_cnt;

    pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .hazard_stall(hazard_stall), .branch_taken(branch_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt_req(halt_req),
        .PCwriteEn(PCwriteEn), .IFIDwriteEn(IFIDwriteEn), .IDEXwriteEn(IDEXwriteEn),
        .EXMEMwriteEn(EXMEMwriteEn), .MEMWBwriteEn(MEMWBwriteEn),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .err(err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit     m_boot, m_halt, m_memw, m_fetw, m_err;
    int     m_wait;
    longint m_scnt;
    bit     p_halt, p_memw, p_fetw, p_err;
    int     p_wait;
    longint p_scnt;
    logic [6:0] e_vec;

    function automatic void model_init();
        m_boot = 1; m_halt = 0; m_memw = 0; m_fetw = 0; m_err = 0; m_wait = 0; m_scnt = 0;
    endfunction

    function automatic void model_eval();
        p_halt = m_halt; p_memw = 0; p_fetw = 0; p_wait = 0; p_err = m_err;
        if (m_boot || m_halt) e_vec = ALL0;
        else if (m_memw) begin
            if (dmem_stall) begin e_vec = ALL0; p_memw = 1; p_wait = m_wait + 1; end
            else e_vec = NORM;
        end else if (m_fetw) begin
            if (dmem_stall) begin e_vec = ALL0; p_memw = 1; end
            else if (imem_stall) begin e_vec = FETCH; p_fetw = 1; p_wait = m_wait + 1; end
            else e_vec = NORM;
        end else begin
            if (halt_req) begin e_vec = ALL0; p_halt = 1; end
            else if (dmem_stall) begin e_vec = ALL0; p_memw = 1; end
            else if (imem_stall) begin e_vec = FETCH; p_fetw = 1; end
            else if (branch_taken) e_vec = BRAN;
            else if (hazard_stall) e_vec = HAZ;
            else e_vec = NORM;
        end
        if (p_wait >= TO) p_err = 1;
        p_scnt = m_scnt;
        if (CNT_EN && !m_boot && !m_halt && !e_vec[6] && m_scnt < SMAX) p_scnt = m_scnt + 1;
    endfunction

    task automatic cmp_all(input string tag);
        logic [6:0] obs;
        obs = {PCwriteEn, IFIDwriteEn, IDEXwriteEn, EXMEMwriteEn, MEMWBwriteEn, ifid_flush, idex_flush};
        n_cmp++;
        assert (obs === e_vec) else begin
            n_err++; $error("FAIL %s ctl observed=%b expected=%b", tag, obs, e_vec);
        end
        n_cmp++;
        assert (halted === m_halt) else begin
            n_err++; $error("FAIL %s halted observed=%b expected=%b", tag, halted, m_halt);
        end
        n_cmp++;
        assert (err === m_err) else begin
            n_err++; $error("FAIL %s err observed=%b expected=%b", tag, err, m_err);
        end
        n_cmp++;
        assert (stall_cnt === m_scnt[CW-1:0]) else begin
            n_err++; $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, m_scnt[CW-1:0]);
        end
    endtask

    task automatic set_in(input logic h, input logic b, input logic im, input logic dm, input logic hr);
        hazard_stall = h; branch_taken = b; imem_stall = im; dmem_stall = dm; halt_req = hr;
    endtask

    task automatic cyc(input string tag);
        model_eval();
        #1;
        cmp_all(tag);
        @(posedge clk);
        if (rst_n) begin
            m_boot = 0; m_halt = p_halt; m_memw = p_memw; m_fetw = p_fetw;
            m_wait = p_wait; m_err = p_err; m_scnt = p_scnt;
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse(input string tag);
        #2 rst_n = 0;
        #1;
        model_init();
        model_eval();
        cmp_all(tag);
        @(posedge clk);
        @(negedge clk);
        model_eval();
        cmp_all(tag);
        rst_n = 1;
    endtask

    initial begin
        int burst;
        model_init();
        @(negedge clk);
        model_eval();
        cmp_all("reset");
        rst_n = 1;
        set_in(0, 0, 0, 0, 0);
        cyc("boot");
        repeat (3) cyc("run_idle");

        set_in(1, 0, 0, 0, 0);
        repeat (2) cyc("hazard");
        set_in(0, 0, 0, 0, 0);
        cyc("hazard_end");

        set_in(1, 1, 0, 0, 0);
        cyc("haz_branch");
        set_in(0, 1, 0, 0, 0);
        cyc("branch");

        set_in(0, 0, 0, 1, 0);
        for (int j = 0; j < 20; j++) begin
            n_cmp++;
            assert (err === (j >= TO + 1)) else begin
                n_err++; $error("FAIL dmem_timeout_err j=%0d observed=%b expected=%b", j, err, (j >= TO + 1));
            end
            cyc("dmem_wait");
        end
        set_in(0, 0, 0, 0, 0);
        repeat (2) cyc("dmem_release");

        set_in(0, 0, 1, 0, 0);
        cyc("imem_1");
        set_in(0, 0, 1, 1, 0);
        repeat (2) cyc("imem_dmem");
        set_in(0, 0, 0, 1, 0);
        repeat (2) cyc("dmem_after_imem");
        set_in(0, 0, 0, 0, 0);
        cyc("fetch_done");

        set_in(0, 0, 1, 0, 0);
        repeat (3) cyc("imem_only");
        set_in(0, 0, 0, 0, 0);
        cyc("imem_release");

        reset_pulse("reset_mid");
        set_in(0, 0, 0, 0, 0);
        cyc("boot2");
        set_in(0, 0, 0, 0, 1);
        cyc("halt_req");
        set_in(0, 0, 0, 0, 0);
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            assert (halted === 1'b1) else begin
                n_err++; $error("FAIL halted_hold observed=%b expected=1", halted);
            end
            cyc("halted");
        end
        reset_pulse("reset_halted");
        cyc("boot3");
        n_cmp++;
        assert (halted === 1'b0) else begin
            n_err++; $error("FAIL halted_cleared observed=%b expected=0", halted);
        end
        cyc("run_after_halt");

        burst = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                reset_pulse("rand_reset");
                burst = 0;
            end
            if (burst > 0) burst--;
            else if ($urandom_range(0, 99) < 6) burst = $urandom_range(1, 20);
            set_in(1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 15),
                   1'($urandom_range(0, 99) < 12), 1'(burst > 0), 1'($urandom_range(0, 199) < 2));
            cyc("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum MEM_WAIT/FETCH_WAIT cycles before the error flag sets (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall cycle counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port hazard_stall, input, 1: RAW stall request from hazard detection.
REQ-006 SHALL have port branch_taken, input, 1: branch/jump resolved taken in EX; redirect PC.
REQ-007 SHALL have ports imem_stall and dmem_stall, input, 1 each: memory busy, held high until the access is done.
REQ-008 SHALL have port halt_req, input, 1: HALT instruction present in MEM/WB.
REQ-009 SHALL have ports PCwriteEn, IFIDwriteEn, IDEXwriteEn, EXMEMwriteEn, MEMWBwriteEn, output, 1 each: per-stage register write enables.
REQ-010 SHALL have ports ifid_flush and idex_flush, output, 1 each: bubble insertion into IF/ID and ID/EX.
REQ-011 SHALL have ports halted and err, output, 1 each: core halted; sticky watchdog error.
REQ-012 SHALL have port stall_cnt, output, CNT_W: stall cycle count (see Configuration).

Function
REQ-013 SHALL implement states BOOT, RUN, MEM_WAIT, FETCH_WAIT and HALTED.
REQ-014 BOOT SHALL be the reset state, drive all enables and flushes to 0, and go to RUN unconditionally on the first clock after rst_n rises.
REQ-015 RUN input priority SHALL be: halt_req > dmem_stall > imem_stall > branch_taken > hazard_stall.
REQ-016 RUN with halt_req SHALL drive all enables 0 and go to HALTED; HALTED SHALL hold all enables 0 with halted=1 until reset.
REQ-017 RUN with dmem_stall SHALL drive all five enables 0 in that same cycle and go to MEM_WAIT.
REQ-018 MEM_WAIT SHALL hold all enables 0 while dmem_stall=1, and in the first cycle with dmem_stall=0 SHALL assert all enables and return to RUN.
REQ-019 RUN with imem_stall (and no dmem_stall) SHALL drive PCwriteEn=0, IFIDwriteEn=1, ifid_flush=1 and later-stage enables 1, then go to FETCH_WAIT.
REQ-020 FETCH_WAIT SHALL keep the REQ-019 outputs while imem_stall=1, SHALL go to MEM_WAIT if dmem_stall rises, and SHALL return to RUN with normal outputs when imem_stall=0.
REQ-021 RUN with branch_taken SHALL drive all enables 1 and ifid_flush=idex_flush=1, overriding a coincident hazard_stall.
REQ-022 RUN with hazard_stall only SHALL drive PCwriteEn=IFIDwriteEn=0, idex_flush=1, and the other enables 1.
REQ-023 RUN with no request SHALL drive all enables 1 and both flushes 0.
REQ-024 All outputs SHALL be combinational from state and inputs, with zero-cycle latency from a request to the enable change.
REQ-025 SHALL keep an 8-bit wait counter that clears on entry to MEM_WAIT/FETCH_WAIT and increments each cycle in those states.
REQ-026 When the wait counter reaches TIMEOUT, err SHALL set and stay set until reset; the FSM SHALL keep waiting and the counter SHALL saturate.
REQ-027 Leaving a wait state and re-entering it on the next cycle SHALL restart the wait counter from 0.

Reset
REQ-028 rst_n low SHALL immediately force state=BOOT, all enables 0, all flushes 0, halted=0, err=0, stall_cnt=0 and wait counter=0, independent of clk.
REQ-029 Reset asserted mid-wait or mid-HALTED SHALL abandon that state with no residual effect after release.

Configuration
REQ-030 With macro PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment once per clock in which PCwriteEn=0 outside BOOT/HALTED, saturating at all-ones.
REQ-031 Without PIPE_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-032 Release reset, all inputs 0 -> cycle 0 all enables 0 (BOOT); cycle 1 onward all enables 1 and flushes 0.
REQ-033 hazard_stall=1 for 2 cycles in RUN -> PCwriteEn=IFIDwriteEn=0 and idex_flush=1 for exactly 2 cycles; stall_cnt=2 with PIPE_STALL_CNT_EN defined.
REQ-034 hazard_stall=1 and branch_taken=1 in the same cycle -> all enables 1 and both flushes 1.
REQ-035 dmem_stall=1 for 20 cycles with TIMEOUT=15 -> all enables 0 for 20 cycles, err=1 from the 16th wait cycle, enables 1 on the cycle dmem_stall drops, err remains 1.
REQ-036 imem_stall=1 for 3 cycles with dmem_stall rising on the 2nd -> FETCH_WAIT outputs for 1 cycle, then all enables 0 until dmem_stall=0.
REQ-037 halt_req=1 then rst_n pulsed low mid-HALTED -> halted=1 and all enables 0 until the pulse; after release BOOT, then RUN with halted=0.
